if_pc_redirect: RTL and testbench
=================================

Name: if_pc_redirect

Overview:
Fetch-stage program-counter owner and the consuming end of the execute-stage branch/jump target path. It holds the architectural fetch PC and advances it by 4 each cycle. It accepts redirect requests (target = pc + extimm, computed in EX) and squashes wrong-path instructions in IF/ID and ID/EX. It also traps on misaligned targets. It sits between the hazard unit, the EX target adder and the synchronous instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the saturating redirect counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  hazard unit stall (load-use); hold PC
redirect_valid_i  input  1  EX requests a PC redirect (taken branch/jump), single-cycle pulse
redirect_target_i  input  32  redirect target from EX target adder
pc_o  output  32  current fetch PC, drives imem address
pc_plus4_o  output  32  pc_o + 4 (mod 2^32), combinational
imem_req_o  output  1  instruction memory read enable
flush_ifid_o  output  1  squash IF/ID register contents at next edge
flush_idex_o  output  1  squash ID/EX register contents at next edge
misalign_o  output  1  sticky misaligned-target trap flag
redirect_cnt_o  output  CNT_W  number of accepted redirects, saturating

Behaviour:
- Reset (async, rst_n=0): pc_o=RESET_PC, state=RUN, misalign_o=0, redirect_cnt_o=0. Reset applies immediately, mid-operation included; all pending flush/trap state is discarded.
- Reset output values: imem_req_o=1, flush_ifid_o=0, flush_idex_o=0.
- States:
  - RUN: normal fetch.
  - FLUSH: one-cycle bubble covering the wrong-path instruction returned by the synchronous imem.
  - TRAP: fetch halted.
- Arithmetic: all PC math is 32-bit unsigned modulo 2^32; 0xFFFF_FFFC+4 = 0x0000_0000. No carry-out.
- Aligned means redirect_target_i[1:0]==2'b00.
- RUN, redirect_valid_i=1, aligned target:
  - pc_o <= target; state <= FLUSH; redirect_cnt_o increments.
  - flush_ifid_o=1 and flush_idex_o=1 combinationally in this cycle.
- RUN, redirect_valid_i=1, misaligned target:
  - state <= TRAP; misalign_o <= 1; pc_o holds; counter unchanged.
  - flush_ifid_o=flush_idex_o=1 in this cycle.
- RUN, no redirect, stall_i=1: pc_o holds; no flush.
- RUN, no redirect, stall_i=0: pc_o <= pc_o+4.
- Redirect has priority over stall. If both are asserted, the redirect is taken and the stall is ignored for PC update.
- FLUSH:
  - flush_ifid_o=1, flush_idex_o=0.
  - Lasts exactly one cycle, then returns to RUN.
  - PC advances by 4 unless stall_i=1, in which case it holds.
- FLUSH with a new redirect_valid_i: handled exactly as in RUN. Aligned → reload pc_o, stay in FLUSH, count it, both flushes=1. Misaligned → TRAP.
- TRAP:
  - imem_req_o=0; pc_o frozen; flush_ifid_o=1, flush_idex_o=0 every cycle.
  - All inputs ignored; exit only via reset.
- imem_req_o=1 in RUN and FLUSH.
- redirect_cnt_o saturates at all-ones; further accepted redirects leave it unchanged.
- pc_plus4_o always equals pc_o+4, including while in TRAP.

Test Plan:
- Reset then 4 cycles free-run, RESET_PC=0 -> pc_o sequence 0,4,8,C,10; flushes 0; imem_req_o=1.
- At pc_o=0x10, pulse redirect to 0x100 -> same cycle flush_ifid_o=flush_idex_o=1; next cycle pc_o=0x100, FLUSH (flush_ifid_o=1 only); following cycle pc_o=0x104, RUN; redirect_cnt_o=1.
- stall_i=1 and redirect to 0x40 in the same cycle -> pc_o=0x40 next cycle; stall_i=1 held one more cycle -> pc_o stays 0x40.
- Redirect to 0x202 -> misalign_o=1, pc_o frozen, imem_req_o=0; further redirects/stalls have no effect; rst_n low -> pc_o=RESET_PC, misalign_o=0 immediately without a clock edge.
- Back-to-back redirects: 0x80, then 0x300 during FLUSH -> pc_o=0x80 then 0x300; flush_idex_o=1 on both cycles; redirect_cnt_o=2.
- Redirect to 0xFFFF_FFFC, run 2 cycles -> pc_o=0x0000_0000 then 0x4. Also, with CNT_W=2, 4 redirects -> redirect_cnt_o saturates at 3.

Source files
------------

// File: rtl/if_pc_redirect.sv
// ============================================================================
//  Module   : if_pc_redirect
//  Purpose  : Fetch PC owner; applies EX branch/jump redirects, squashes
//             wrong-path IF/ID and ID/EX contents, traps on misaligned targets.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module if_pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [31:0]      redirect_target_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             imem_req_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      w_pc_plus4;
  logic             w_aligned;
  logic             w_flush_ifid;
  logic             w_flush_idex;
  logic             w_imem_req;

  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_aligned  = (redirect_target_i[1:0] == 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misalign_d   = misalign_q;
    cnt_d        = cnt_q;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    w_imem_req   = 1'b1;

    case (state_q)
      ST_RUN, ST_FLUSH: begin
        // The imem returns the instruction fetched before the redirect one
        // cycle late, so FLUSH keeps IF/ID squashed for that bubble.
        w_flush_ifid = (state_q == ST_FLUSH);
        if (redirect_valid_i) begin
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
          if (w_aligned) begin
            pc_d    = redirect_target_i;
            state_d = ST_FLUSH;
            if (cnt_q != c_cnt_max) begin
              cnt_d = cnt_q + c_cnt_one;
            end
          end else begin
            state_d    = ST_TRAP;
            misalign_d = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
          if (!stall_i) begin
            pc_d = w_pc_plus4;
          end
        end
      end
      ST_TRAP: begin
        w_imem_req   = 1'b0;
        w_flush_ifid = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o           = pc_q;
  assign pc_plus4_o     = w_pc_plus4;
  assign imem_req_o     = w_imem_req;
  assign flush_ifid_o   = w_flush_ifid;
  assign flush_idex_o   = w_flush_idex;
  assign misalign_o     = misalign_q;
  assign redirect_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_if_pc_redirect.sv
// ============================================================================
//  Module   : tb_if_pc_redirect
//  Purpose  : Directed scoreboard bench for if_pc_redirect (CNT_W = 2).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_pc_redirect;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             stall_i;
  logic             redirect_valid_i;
  logic [31:0]      redirect_target_i;
  logic [31:0]      pc_o;
  logic [31:0]      pc_plus4_o;
  logic             imem_req_o;
  logic             flush_ifid_o;
  logic             flush_idex_o;
  logic             misalign_o;
  logic [CNT_W-1:0] redirect_cnt_o;

  if_pc_redirect #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .pc_o              (pc_o),
    .pc_plus4_o        (pc_plus4_o),
    .imem_req_o        (imem_req_o),
    .flush_ifid_o      (flush_ifid_o),
    .flush_idex_o      (flush_idex_o),
    .misalign_o        (misalign_o),
    .redirect_cnt_o    (redirect_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        fi;
    logic        fe;
    logic        req;
    logic        mis;
    logic [1:0]  cnt;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_idx = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        chk("pc",       vec_idx, pc_o,                   e.pc);
        chk("pc_plus4", vec_idx, pc_plus4_o,             e.pc + 32'd4);
        chk("flush_ifid", vec_idx, {31'd0, flush_ifid_o}, {31'd0, e.fi});
        chk("flush_idex", vec_idx, {31'd0, flush_idex_o}, {31'd0, e.fe});
        chk("imem_req", vec_idx, {31'd0, imem_req_o},    {31'd0, e.req});
        chk("misalign", vec_idx, {31'd0, misalign_o},    {31'd0, e.mis});
        chk("cnt",      vec_idx, {30'd0, redirect_cnt_o}, {30'd0, e.cnt});
        vec_idx++;
      end
    end
  end

  // One cycle of stimulus: inputs driven 1 ns after the rising edge, with the
  // hand-computed outputs expected for that same cycle.
  task automatic cyc(input logic rst, input logic stall, input logic rv,
                     input logic [31:0] tgt, input logic [31:0] epc,
                     input logic efi, input logic efe, input logic ereq,
                     input logic emis, input logic [1:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n             = rst;
    stall_i           = stall;
    redirect_valid_i  = rv;
    redirect_target_i = tgt;
    e.pc  = epc;
    e.fi  = efi;
    e.fe  = efe;
    e.req = ereq;
    e.mis = emis;
    e.cnt = ecnt;
    q_exp.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    stall_i           = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_target_i = 32'h0;

    //  rst stl rv  target        pc            fi fe rq ms cnt
    cyc(0, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 1, 0, 2'd0); // reset
    cyc(1, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 1, 0, 2'd0);
    cyc(1, 0, 0, 32'h0,         32'h0000_0004, 0, 0, 1, 0, 2'd0);
    cyc(1, 0, 0, 32'h0,         32'h0000_0008, 0, 0, 1, 0, 2'd0);
    cyc(1, 0, 0, 32'h0,         32'h0000_000C, 0, 0, 1, 0, 2'd0);
    // redirect to 0x100
    cyc(1, 0, 1, 32'h100,       32'h0000_0010, 1, 1, 1, 0, 2'd0);
    cyc(1, 0, 0, 32'h0,         32'h0000_0100, 1, 0, 1, 0, 2'd1);
    cyc(1, 0, 0, 32'h0,         32'h0000_0104, 0, 0, 1, 0, 2'd1);
    // redirect wins over stall, then stall holds during FLUSH
    cyc(1, 1, 1, 32'h40,        32'h0000_0108, 1, 1, 1, 0, 2'd1);
    cyc(1, 1, 0, 32'h0,         32'h0000_0040, 1, 0, 1, 0, 2'd2);
    cyc(1, 0, 0, 32'h0,         32'h0000_0040, 0, 0, 1, 0, 2'd2);
    cyc(1, 0, 0, 32'h0,         32'h0000_0044, 0, 0, 1, 0, 2'd2);
    // back-to-back redirects; fourth accepted redirect saturates the counter
    cyc(1, 0, 1, 32'h80,        32'h0000_0048, 1, 1, 1, 0, 2'd2);
    cyc(1, 0, 1, 32'h300,       32'h0000_0080, 1, 1, 1, 0, 2'd3);
    cyc(1, 0, 0, 32'h0,         32'h0000_0300, 1, 0, 1, 0, 2'd3);
    cyc(1, 0, 0, 32'h0,         32'h0000_0304, 0, 0, 1, 0, 2'd3);
    // PC wraps modulo 2^32
    cyc(1, 0, 1, 32'hFFFF_FFFC, 32'h0000_0308, 1, 1, 1, 0, 2'd3);
    cyc(1, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 0, 1, 0, 2'd3);
    cyc(1, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 1, 0, 2'd3);
    cyc(1, 0, 0, 32'h0,         32'h0000_0004, 0, 0, 1, 0, 2'd3);
    // misaligned target traps; later inputs are ignored
    cyc(1, 0, 1, 32'h202,       32'h0000_0008, 1, 1, 1, 0, 2'd3);
    cyc(1, 0, 1, 32'h400,       32'h0000_0008, 1, 0, 0, 1, 2'd3);
    cyc(1, 1, 0, 32'h0,         32'h0000_0008, 1, 0, 0, 1, 2'd3);
    cyc(1, 0, 0, 32'h0,         32'h0000_0008, 1, 0, 0, 1, 2'd3);
    // async reset: sampled before any further rising edge
    cyc(0, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 1, 0, 2'd0);
    cyc(1, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 1, 0, 2'd0);
    cyc(1, 0, 1, 32'h10,        32'h0000_0004, 1, 1, 1, 0, 2'd0);
    cyc(1, 0, 0, 32'h0,         32'h0000_0010, 1, 0, 1, 0, 2'd1);
    cyc(1, 0, 0, 32'h0,         32'h0000_0014, 0, 0, 1, 0, 2'd1);

    repeat (3) @(negedge clk);
    n_tests++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
